// File: rtl/adder_scheduler_if.sv
// ---------------------------------------------------------------------------
// adder_scheduler_if
//   Bundle of every request, adder and response signal around the
//   two-client adder scheduler.
//
//   Request side  : req0/a0/b0, req1/a1/b1 in, gnt0/gnt1 pulses out.
//   Adder side    : add_a/add_b out to the shared adder, add_sum/add_cout back.
//   Response side : result/result_id/result_valid out, rsp_ready in.
//   Status        : busy is high whenever the scheduler is not idle.
//
//   Response handshake: a response transfers on a rising edge where
//   result_valid and rsp_ready are both 1. Once result_valid rises, the
//   result and result_id do not change until that transfer. rsp_ready
//   has no effect while result_valid is 0.
//
//   slave  : the scheduler.
//   master : the surrounding clients, the adder and the response consumer.
// ---------------------------------------------------------------------------
interface adder_scheduler_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH:0]   result;
    logic             result_id;
    logic             result_valid;
    logic             rsp_ready;
    logic             busy;

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        input  add_sum, add_cout, rsp_ready,
        output gnt0, gnt1, add_a, add_b,
        output result, result_id, result_valid, busy
    );

    modport master (
        output req0, a0, b0, req1, a1, b1,
        output add_sum, add_cout, rsp_ready,
        input  gnt0, gnt1, add_a, add_b,
        input  result, result_id, result_valid, busy
    );
endinterface

// File: rtl/adder_scheduler.sv
// ---------------------------------------------------------------------------
// adder_scheduler
//   Round-robin scheduler that lets two clients share one combinational
//   adder. In IDLE the winning client's operands are latched into add_a/
//   add_b, one cycle later {add_cout, add_sum} is captured into result,
//   and the result is held until the consumer accepts it.
//
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous active-low reset
//     bus      adder_scheduler_if.slave (requests, adder, response, busy)
//     state_o  current FSM state for debug (IDLE=0, EXEC=1, DONE=2)
// ---------------------------------------------------------------------------
module adder_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    adder_scheduler_if.slave    bus,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;
    logic [WIDTH:0]   result_q;
    logic             result_id_q;
    logic             result_valid_q;
    logic             last_grant_q;

    logic             winner_d;
    logic [WIDTH-1:0] win_a_d;
    logic [WIDTH-1:0] win_b_d;

    // A lone requester wins outright; under contention the requester that
    // was not granted last wins. Only meaningful when some req is high.
    always_comb begin
        winner_d = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner_d = ~last_grant_q;
        end else begin
            winner_d = bus.req1;
        end
        win_a_d = winner_d ? bus.a1 : bus.a0;
        win_b_d = winner_d ? bus.b1 : bus.b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            gnt0_q         <= 1'b0;
            gnt1_q         <= 1'b0;
            add_a_q        <= '0;
            add_b_q        <= '0;
            result_q       <= '0;
            result_id_q    <= 1'b0;
            result_valid_q <= 1'b0;
            // Pretend requester 1 was served last so 0 wins first contention.
            last_grant_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        gnt0_q       <= ~winner_d;
                        gnt1_q       <= winner_d;
                        add_a_q      <= win_a_d;
                        add_b_q      <= win_b_d;
                        result_id_q  <= winner_d;
                        last_grant_q <= winner_d;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    // add_a/add_b were registered last edge, so the adder
                    // has had a full period to settle.
                    gnt0_q         <= 1'b0;
                    gnt1_q         <= 1'b0;
                    result_q       <= {bus.add_cout, bus.add_sum};
                    result_valid_q <= 1'b1;
                    state_q        <= DONE;
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        result_valid_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    gnt0_q         <= 1'b0;
                    gnt1_q         <= 1'b0;
                    result_valid_q <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0         = gnt0_q;
    assign bus.gnt1         = gnt1_q;
    assign bus.add_a        = add_a_q;
    assign bus.add_b        = add_b_q;
    assign bus.result       = result_q;
    assign bus.result_id    = result_id_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = (state_q != IDLE);
    assign state_o          = state_q;

endmodule

// File: tb/tb_adder_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adder_scheduler
//   Directed and randomized checks of adder_scheduler. The shared adder is
//   modelled here as a plain continuous add. Expected grants come from a
//   round-robin reference (who was served last) and expected results from
//   9-bit arithmetic on the winner's operands.
// ---------------------------------------------------------------------------
module tb_adder_scheduler;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adder_scheduler_if #(.WIDTH(W)) bus ();
    logic [1:0] state_o;

    adder_scheduler #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    // Shared combinational adder, carry-in 0.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    // ---------------- scoreboard state ----------------
    int           tests = 0;
    int           fails = 0;
    int           exp_last;            // requester granted most recently
    logic [W:0]   exp_q[$];            // expected results in grant order

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.a0        = '0;
        bus.b0        = '0;
        bus.a1        = '0;
        bus.b1        = '0;
        bus.rsp_ready = 1'b0;
    endtask

    // Model: a lone requester wins; under contention the one not served last.
    function automatic int pick_winner(input bit r0, input bit r1);
        if (r0 && r1) return 1 - exp_last;
        return r1 ? 1 : 0;
    endfunction

    // One complete transaction from IDLE, with `stall` cycles of rsp_ready=0.
    task automatic run_op(input bit r0, input bit r1,
                          input logic [W-1:0] x0, input logic [W-1:0] y0,
                          input logic [W-1:0] x1, input logic [W-1:0] y1,
                          input int stall);
        int         win;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W:0] exp_res;
        bus.req0 = r0;  bus.a0 = x0;  bus.b0 = y0;
        bus.req1 = r1;  bus.a1 = x1;  bus.b1 = y1;
        win      = pick_winner(r0, r1);
        exp_last = win;
        ea       = (win == 1) ? x1 : x0;
        eb       = (win == 1) ? y1 : y0;
        exp_q.push_back((W+1)'(ea) + (W+1)'(eb));
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("gnt0", bus.gnt0, (win == 0));
        check("gnt1", bus.gnt1, (win == 1));
        check("busy_exec", bus.busy, 1);
        check("add_a", bus.add_a, ea);
        check("add_b", bus.add_b, eb);
        check("valid_exec", bus.result_valid, 0);
        tick();
        exp_res = exp_q.pop_front();
        check("result", bus.result, exp_res);
        check("result_id", bus.result_id, win);
        check("valid_done", bus.result_valid, 1);
        check("gnt_clear", {bus.gnt0, bus.gnt1}, 0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("result_hold", bus.result, exp_res);
            check("valid_hold", bus.result_valid, 1);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("valid_clear", bus.result_valid, 0);
        check("busy_idle", bus.busy, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W:0] held;
        int win;
        drive_idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
        check("rst_valid", bus.result_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_id", bus.result_id, 0);
        check("rst_result", bus.result, 0);
        check("rst_add", {bus.add_a, bus.add_b}, 0);
        check("rst_state", state_o, 0);
        rst      = 1'b1;
        exp_last = 1;

        // Contention with rsp_ready tied high: 0,1,0,1 every 3 cycles.
        bus.req0 = 1'b1;  bus.a0 = 8'h11;  bus.b0 = 8'h22;
        bus.req1 = 1'b1;  bus.a1 = 8'hF0;  bus.b1 = 8'h20;
        bus.rsp_ready = 1'b1;
        win = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            case (i % 3)
                0: begin
                    win      = 1 - exp_last;
                    exp_last = win;
                    check("cont_gnt0", bus.gnt0, (win == 0));
                    check("cont_gnt1", bus.gnt1, (win == 1));
                    check("cont_busy", bus.busy, 1);
                end
                1: begin
                    check("cont_valid", bus.result_valid, 1);
                    check("cont_id", bus.result_id, win);
                    check("cont_result", bus.result, (win == 1) ? 9'h110 : 9'h033);
                end
                default: begin
                    check("cont_busy_low", bus.busy, 0);
                    check("cont_valid_low", bus.result_valid, 0);
                end
            endcase
        end
        drive_idle();
        tick();

        // Directed single adds, carry cases and corners
        run_op(1, 0, 8'h25, 8'h13, 8'h00, 8'h00, 2);
        check("single_const", bus.result, 9'h038);
        run_op(0, 1, 8'h00, 8'h00, 8'hFF, 8'h01, 0);
        check("carry_const", bus.result, 9'h100);
        run_op(0, 1, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
        check("carry_max", bus.result, 9'h1FE);
        run_op(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        run_op(1, 0, 8'h80, 8'h80, 8'h00, 8'h00, 1);

        // Stall in DONE for 10 cycles while toggling req0/a0
        bus.req0 = 1'b1;  bus.a0 = 8'h40;  bus.b0 = 8'h02;
        exp_last = 0;
        tick();
        bus.req0 = 1'b0;
        tick();
        held = 9'h042;
        check("stall_first", bus.result, held);
        for (int i = 0; i < 10; i++) begin
            bus.req0 = 1'($urandom_range(0, 1));
            bus.a0   = W'($urandom);
            tick();
            check("stall_result", bus.result, held);
            check("stall_id", bus.result_id, 0);
            check("stall_valid", bus.result_valid, 1);
            check("stall_gnt", {bus.gnt0, bus.gnt1}, 0);
        end
        bus.req0      = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("stall_release_valid", bus.result_valid, 0);
        check("stall_release_busy", bus.busy, 0);

        // Async reset in the middle of EXEC
        bus.req0 = 1'b1;  bus.a0 = 8'h7F;  bus.b0 = 8'h7F;
        tick();
        bus.req0 = 1'b0;
        check("pre_rst_gnt0", bus.gnt0, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_gnt", {bus.gnt0, bus.gnt1}, 0);
        check("arst_valid", bus.result_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_id", bus.result_id, 0);
        check("arst_result", bus.result, 0);
        check("arst_add", {bus.add_a, bus.add_b}, 0);
        exp_last = 1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", bus.result_valid, 0);
            check("post_rst_busy", bus.busy, 0);
        end
        run_op(1, 1, 8'h01, 8'h02, 8'h03, 8'h04, 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            bit r0;
            bit r1;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            run_op(r0, r1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                   $urandom_range(0, 2));
        end

        check("queue_empty", exp_q.size(), 0);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
